// File: rtl/argmax_frame_sequencer.sv
// Framed argmax: per-beat lane argmax feeding a serial running-max over NUM_GROUPS beats.
// Optional max_value result port is enabled by defining ARGMAX_MAX_OUT_EN.
module argmax_frame_sequencer #(
    parameter int WIDTH      = 8,
    parameter int LANES      = 4,
    parameter int NUM_GROUPS = 4,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef ARGMAX_MAX_OUT_EN
    output logic [IDX_WIDTH-1:0]   argmax,
    output logic [WIDTH-1:0]       max_value
`else
    output logic [IDX_WIDTH-1:0]   argmax
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds data stable while valid is high and ready is low.

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [WIDTH-1:0] MAX_RESET = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                       state, state_d;
    logic [IDX_WIDTH-1:0]         group, group_d;
    logic signed [WIDTH-1:0]      run_max, run_max_d;
    logic [IDX_WIDTH-1:0]         run_idx, run_idx_d;
    logic signed [WIDTH-1:0]      lane_max;
    logic [IDX_WIDTH-1:0]         lane_idx;

    // Strict compare keeps the lowest lane on ties.
    always_comb begin
        lane_max = $signed(in_data[WIDTH-1:0]);
        lane_idx = '0;
        for (int k = 1; k < LANES; k++) begin
            if ($signed(in_data[k*WIDTH +: WIDTH]) > lane_max) begin
                lane_max = $signed(in_data[k*WIDTH +: WIDTH]);
                lane_idx = IDX_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            group   <= '0;
            run_max <= MAX_RESET;
            run_idx <= '0;
        end else begin
            state   <= state_d;
            group   <= group_d;
            run_max <= run_max_d;
            run_idx <= run_idx_d;
        end
    end

    always_comb begin
        state_d   = state;
        group_d   = group;
        run_max_d = run_max;
        run_idx_d = run_idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    run_max_d = lane_max;
                    run_idx_d = lane_idx;
                    group_d   = IDX_WIDTH'(1);
                    state_d   = (NUM_GROUPS == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    // Ties across groups keep the earlier group.
                    if (lane_max > run_max) begin
                        run_max_d = lane_max;
                        run_idx_d = group * IDX_WIDTH'(LANES) + lane_idx;
                    end
                    group_d = group + IDX_WIDTH'(1);
                    if (group == IDX_WIDTH'(NUM_GROUPS - 1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    group_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            group_d   = '0;
            run_max_d = MAX_RESET;
            run_idx_d = '0;
        end
    end

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign argmax    = run_idx;

`ifdef ARGMAX_MAX_OUT_EN
    assign max_value = out_valid ? run_max : '0;
`endif

endmodule

// File: tb/tb_argmax_frame_sequencer.sv
// Directed bench for argmax_frame_sequencer: frame-level reference model plus literal result checks.
// Define ARGMAX_MAX_OUT_EN to also cover the max_value port.
module tb_argmax_frame_sequencer;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int NG = 4;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [L*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [IW-1:0]  argmax;
`ifdef ARGMAX_MAX_OUT_EN
    logic [W-1:0]   max_value;
`endif

    int n_cmp = 0;
    int n_err = 0;

    argmax_frame_sequencer #(.WIDTH(W), .LANES(L), .NUM_GROUPS(NG), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ARGMAX_MAX_OUT_EN
        .argmax    (argmax),
        .max_value (max_value)
`else
        .argmax    (argmax)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [L*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // ---------------- reference model ----------------
    // Collects every accepted element of a frame in order, then scans the flat list.
    int m_el[NG*L];
    int m_cnt  = 0;
    bit m_pend = 1'b0;
    int m_idx  = 0;
    int m_max  = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || flush) begin
                m_cnt  = 0;
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (out_ready) begin
                    m_pend = 1'b0;
                    m_cnt  = 0;
                end
            end else if (in_valid) begin
                for (int k = 0; k < L; k++)
                    m_el[m_cnt*L + k] = int'($signed(in_data[k*W +: W]));
                m_cnt++;
                if (m_cnt == NG) begin
                    m_idx = 0;
                    m_max = m_el[0];
                    for (int i = 1; i < NG*L; i++) begin
                        if (m_el[i] > m_max) begin
                            m_max = m_el[i];
                            m_idx = i;
                        end
                    end
                    m_pend = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(!m_pend));
            chk("out_valid", int'(out_valid), int'(m_pend));
            if (m_pend && out_valid) begin
                chk("argmax_model", int'(argmax), m_idx);
`ifdef ARGMAX_MAX_OUT_EN
                chk("max_value_model", int'($signed(max_value)), m_max);
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [L*W-1:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_beat: in_ready never high, expected acceptance within 20 cycles");
        end
    endtask

    task automatic send_frame(input logic [L*W-1:0] b0, input logic [L*W-1:0] b1,
                              input logic [L*W-1:0] b2, input logic [L*W-1:0] b3);
        send_beat(b0);
        send_beat(b1);
        send_beat(b2);
        send_beat(b3);
    endtask

    task automatic wait_result(input string name, input int exp_idx, input int exp_max);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_argmax"}, int'(argmax), exp_idx);
`ifdef ARGMAX_MAX_OUT_EN
        chk({name, "_max"}, int'($signed(max_value)), exp_max);
`else
        if (exp_max != m_max) chk({name, "_model_max"}, m_max, exp_max);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_argmax", int'(argmax), 0);
`ifdef ARGMAX_MAX_OUT_EN
        chk("rst_max_value", int'(max_value), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, then DONE held with out_ready low and a beat waiting.
        send_frame(pk(1, 2, 3, 4), pk(5, 9, 0, 0), pk(7, 7, 7, 7), pk(-1, 0, 0, 0));
        @(negedge clk);
        chk("a_latency_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_data  = pk(100, 100, 100, 100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_argmax", int'(argmax), 5);
`ifdef ARGMAX_MAX_OUT_EN
            chk("hold_max", int'($signed(max_value)), 9);
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // All minimum values: first beat loads unconditionally, earliest index wins.
        send_frame(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128),
                   pk(-128, -128, -128, -128), pk(-128, -128, -128, -128));
        wait_result("min", 0, -128);

        // Lane tie and cross-group tie.
        send_frame(pk(0, 3, 3, 0), pk(3, 3, 3, 3), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
        wait_result("tie", 1, 3);

        // All negative, winner in group 1 lane 3.
        send_frame(pk(-5, -3, -3, -7), pk(-4, -2, -9, -1), pk(-2, -8, -8, -8), pk(-6, -6, -6, -6));
        wait_result("neg", 7, -1);

        // Flush after two beats; the beat presented with flush is dropped.
        send_beat(pk(120, 0, 0, 0));
        send_beat(pk(0, 127, 0, 0));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = pk(127, 127, 127, 127);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send_frame(pk(1, 2, 3, 4), pk(10, 20, 30, 40), pk(-5, 0, 5, 49), pk(0, 0, 50, 0));
        wait_result("flush", 14, 50);

        // Back-to-back frames with out_ready held high.
        out_ready = 1'b1;
        send_frame(pk(1, 2, 3, 4), pk(5, 9, 0, 0), pk(7, 7, 7, 7), pk(-1, 0, 0, 0));
        send_frame(pk(0, 3, 3, 0), pk(3, 3, 3, 3), pk(0, 0, 0, 0), pk(0, 0, 0, 0));
        @(negedge clk);
        chk("stream_valid", int'(out_valid), 1);
        chk("stream_argmax", int'(argmax), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset mid-frame.
        send_beat(pk(90, 0, 0, 0));
        send_beat(pk(0, 0, 0, 91));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_argmax", int'(argmax), 0);
        chk("arst_in_ready", int'(in_ready), 1);
`ifdef ARGMAX_MAX_OUT_EN
        chk("arst_max_value", int'(max_value), 0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(pk(-5, -3, -3, -7), pk(-4, -2, -9, -1), pk(-2, -8, -8, -8), pk(-6, -6, -6, -6));
        wait_result("post_rst", 7, -1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
